// File: rtl/vrom_pixel_scheduler.sv
// -----------------------------------------------------------------------------
// vrom_pixel_scheduler
//
// Per-pixel read sequencer for the shared video ROM bank (Interfaz 640x480,
// Digitos 40x600, Crono 100x40, all RGB222). For every pixel of the VGA
// coordinate stream it decides which ROM owns the pixel (clock digit slot,
// crono indicator or background), drives the bank's ChipSelector/Address,
// and realigns the registered ROM data with a valid flag to produce RGB.
//
// The time value (Digits/CronoOn/EditField) is shadowed once per frame, on
// the visible (0,0) pixel, so digits never tear mid-frame.
//
// Pipeline (latency 3 cycles from pixel input to RGB):
//   S0  register PixelX/PixelY/VideoOn
//   S1  region decode + address compute, register ChipSelector/Address
//   S2  ROM bank registers RomData (external)
//   S3  valid/select flags aligned with RomData produce RGB/RGBValid
//
// Ports:
//   CLK           system clock, one pixel per cycle
//   RESET         asynchronous active-high reset
//   PixelX/Y      pixel coordinate (10 bits each)
//   VideoOn       pixel lies in the visible area
//   Digits        six BCD digits HHMMSS, [23:20] = slot 0
//   CronoOn       show the crono indicator
//   EditField     0 none, 1 hours, 2 minutes, 3 seconds (blink build only)
//   ChipSelector  00 Interfaz, 01 Digitos, 11 Crono
//   Address       19-bit ROM address
//   RomData       registered ROM output, valid one cycle after Address
//   RGB           final pixel colour
//   RGBValid      RGB belongs to a visible pixel
//
// Optional build macro: VROM_EDIT_BLINK_EN
//   When defined, the digit slots selected by the shadowed EditField are
//   drawn inverted while bit 4 of a 5-bit frame counter is set.
// -----------------------------------------------------------------------------
module vrom_pixel_scheduler #(
    parameter int unsigned DIGIT_X0    = 160,
    parameter int unsigned DIGIT_Y0    = 200,
    parameter int unsigned DIGIT_PITCH = 56,
    parameter int unsigned DIGIT_W     = 40,
    parameter int unsigned DIGIT_H     = 60,
    parameter int unsigned CRONO_X0    = 270,
    parameter int unsigned CRONO_Y0    = 320,
    parameter int unsigned CRONO_W     = 100,
    parameter int unsigned CRONO_H     = 40
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [9:0]  PixelX,
    input  logic [9:0]  PixelY,
    input  logic        VideoOn,
    input  logic [23:0] Digits,
    input  logic        CronoOn,
    input  logic [1:0]  EditField,
    output logic [1:0]  ChipSelector,
    output logic [18:0] Address,
    input  logic [5:0]  RomData,
    output logic [5:0]  RGB,
    output logic        RGBValid
);

    typedef enum logic [1:0] {
        CS_IFZ   = 2'b00,
        CS_DIG   = 2'b01,
        CS_CRONO = 2'b11
    } cs_t;

    localparam int unsigned NUM_SLOTS = 6;

    // Region bounds widened to 11 bits so right/bottom edges never overflow
    // the 10-bit coordinate range.
    localparam logic [10:0] DIG_Y0 = 11'(DIGIT_Y0);
    localparam logic [10:0] DIG_Y1 = 11'(DIGIT_Y0 + DIGIT_H);
    localparam logic [10:0] CRO_X0 = 11'(CRONO_X0);
    localparam logic [10:0] CRO_X1 = 11'(CRONO_X0 + CRONO_W);
    localparam logic [10:0] CRO_Y0 = 11'(CRONO_Y0);
    localparam logic [10:0] CRO_Y1 = 11'(CRONO_Y0 + CRONO_H);
    localparam logic [19:0] IFZ_W  = 20'd640;

    // ------------------------------------------------------------------
    // S0: input capture
    // ------------------------------------------------------------------
    logic [9:0] s0_x_q;
    logic [9:0] s0_y_q;
    logic       s0_vis_q;
    logic       frame_start;

    assign frame_start = VideoOn && (PixelX == 10'd0) && (PixelY == 10'd0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s0_x_q   <= '0;
            s0_y_q   <= '0;
            s0_vis_q <= 1'b0;
        end else begin
            s0_x_q   <= PixelX;
            s0_y_q   <= PixelY;
            s0_vis_q <= VideoOn;
        end
    end

    // ------------------------------------------------------------------
    // Frame shadow: loaded on the same edge that S0 captures the visible
    // (0,0) pixel, so that pixel already decodes with the new values.
    // ------------------------------------------------------------------
    logic [23:0] digits_q;
    logic        crono_on_q;

`ifdef VROM_EDIT_BLINK_EN
    logic [1:0]  edit_q;
    logic [4:0]  frame_cnt_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            digits_q    <= '0;
            crono_on_q  <= 1'b0;
            edit_q      <= '0;
            frame_cnt_q <= '0;
        end else if (frame_start) begin
            digits_q    <= Digits;
            crono_on_q  <= CronoOn;
            edit_q      <= EditField;
            frame_cnt_q <= frame_cnt_q + 5'd1;
        end
    end
`else
    // Edit selection has no effect without the blink feature.
    logic [1:0] unused_edit_field;
    assign unused_edit_field = EditField;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            digits_q   <= '0;
            crono_on_q <= 1'b0;
        end else if (frame_start) begin
            digits_q   <= Digits;
            crono_on_q <= CronoOn;
        end
    end
`endif

    // ------------------------------------------------------------------
    // S1: region decode
    // ------------------------------------------------------------------
    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic [10:0] dig_dy;
    logic        in_digit_rows;

    assign x_ext         = {1'b0, s0_x_q};
    assign y_ext         = {1'b0, s0_y_q};
    assign in_digit_rows = (y_ext >= DIG_Y0) && (y_ext < DIG_Y1);
    assign dig_dy        = y_ext - DIG_Y0;

    logic [NUM_SLOTS-1:0] slot_hit;
    logic [18:0]          slot_addr [NUM_SLOTS];
`ifdef VROM_EDIT_BLINK_EN
    logic [NUM_SLOTS-1:0] slot_edit;
`endif

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            localparam logic [10:0] SLOT_X0 = 11'(DIGIT_X0 + gi * DIGIT_PITCH);
            localparam logic [10:0] SLOT_X1 = 11'(DIGIT_X0 + gi * DIGIT_PITCH + DIGIT_W);

            logic [3:0]  bcd;
            logic [10:0] dx;

            assign bcd = digits_q[23 - 4*gi -: 4];
            assign dx  = x_ext - SLOT_X0;

            // A non-BCD nibble drops the slot to background so Digitos is
            // never read past glyph 9.
            assign slot_hit[gi] = in_digit_rows && (x_ext >= SLOT_X0) &&
                                  (x_ext < SLOT_X1) && (bcd <= 4'd9);

            // Glyph n occupies Digitos rows n*H..n*H+H-1; all terms are
            // 19 bits wide so the product never wraps.
            assign slot_addr[gi] = (19'(bcd) * 19'(DIGIT_H) + 19'(dig_dy)) * 19'(DIGIT_W)
                                   + 19'(dx);

`ifdef VROM_EDIT_BLINK_EN
            // Slots pair up as hours (0,1), minutes (2,3), seconds (4,5).
            localparam logic [1:0] SLOT_FIELD = 2'(gi / 2 + 1);
            assign slot_edit[gi] = (edit_q == SLOT_FIELD);
`endif
        end
    endgenerate

    logic        crono_hit;
    logic [18:0] crono_addr;
    logic [19:0] bg_full;
    logic [18:0] bg_addr;
    logic        unused_bg_msb;

    assign crono_hit  = crono_on_q &&
                        (x_ext >= CRO_X0) && (x_ext < CRO_X1) &&
                        (y_ext >= CRO_Y0) && (y_ext < CRO_Y1);
    assign crono_addr = 19'(y_ext - CRO_Y0) * 19'(CRONO_W) + 19'(x_ext - CRO_X0);

    // 20-bit product covers any 10-bit y; visible rows fit in 19 bits.
    assign bg_full       = 20'(s0_y_q) * IFZ_W + 20'(s0_x_q);
    assign bg_addr       = bg_full[18:0];
    assign unused_bg_msb = bg_full[19];

    cs_t         cs_q;
    cs_t         cs_d;
    logic [18:0] addr_q;
    logic [18:0] addr_d;
`ifdef VROM_EDIT_BLINK_EN
    logic        inv_d;
`endif

    always_comb begin
        // Blanking holds the previous ROM request.
        cs_d   = cs_q;
        addr_d = addr_q;
`ifdef VROM_EDIT_BLINK_EN
        inv_d  = 1'b0;
`endif
        if (s0_vis_q) begin
            cs_d   = CS_IFZ;
            addr_d = bg_addr;
            if (crono_hit) begin
                cs_d   = CS_CRONO;
                addr_d = crono_addr;
            end
            // Descending scan: the lowest-numbered matching slot is applied
            // last and therefore wins; any digit beats the crono.
            for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
                if (slot_hit[i]) begin
                    cs_d   = CS_DIG;
                    addr_d = slot_addr[i];
`ifdef VROM_EDIT_BLINK_EN
                    inv_d  = slot_edit[i] & frame_cnt_q[4];
`endif
                end
            end
        end
    end

    logic v1_q;
    logic v2_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cs_q   <= CS_IFZ;
            addr_q <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            cs_q   <= cs_d;
            addr_q <= addr_d;
            v1_q   <= s0_vis_q;
            // v2_q lines up with RomData returned for the S1 request.
            v2_q   <= v1_q;
        end
    end

    assign ChipSelector = cs_q;
    assign Address      = addr_q;

    // ------------------------------------------------------------------
    // S3: realign ROM data with its valid (and inversion) flag
    // ------------------------------------------------------------------
    logic [5:0] pix;

`ifdef VROM_EDIT_BLINK_EN
    logic inv1_q;
    logic inv2_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            inv1_q <= 1'b0;
            inv2_q <= 1'b0;
        end else begin
            inv1_q <= inv_d;
            inv2_q <= inv1_q;
        end
    end

    assign pix = inv2_q ? ~RomData : RomData;
`else
    assign pix = RomData;
`endif

    assign RGB      = v2_q ? pix : 6'd0;
    assign RGBValid = v2_q;

endmodule

// File: tb/tb_vrom_pixel_scheduler.sv
module tb_vrom_pixel_scheduler;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [9:0]  PixelX;
    logic [9:0]  PixelY;
    logic        VideoOn;
    logic [23:0] Digits;
    logic        CronoOn;
    logic [1:0]  EditField;
    logic [1:0]  ChipSelector;
    logic [18:0] Address;
    logic [5:0]  RomData = 6'd0;
    logic [5:0]  RGB;
    logic        RGBValid;

    int total = 0;
    int bad   = 0;

    vrom_pixel_scheduler dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PixelX       (PixelX),
        .PixelY       (PixelY),
        .VideoOn      (VideoOn),
        .Digits       (Digits),
        .CronoOn      (CronoOn),
        .EditField    (EditField),
        .ChipSelector (ChipSelector),
        .Address      (Address),
        .RomData      (RomData),
        .RGB          (RGB),
        .RGBValid     (RGBValid)
    );

    always #5 CLK = ~CLK;

    // ROM bank model: arbitrary content pattern, one cycle read latency.
    function automatic logic [5:0] rom_fn(input logic [1:0] cs, input logic [18:0] a);
        return a[5:0] ^ a[11:6] ^ {a[18:17], a[15:12]} ^ {cs, cs, cs};
    endfunction

    always @(posedge CLK) RomData <= rom_fn(ChipSelector, Address);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_px(input int x, input int y, input logic v);
        PixelX  = 10'(x);
        PixelY  = 10'(y);
        VideoOn = v;
    endtask

    // Visible (0,0) pixel with new time inputs, then flush.
    task automatic frame_start(input logic [23:0] d, input logic c, input logic [1:0] e);
        Digits    = d;
        CronoOn   = c;
        EditField = e;
        set_px(0, 0, 1'b1);
        tick();
        VideoOn = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // One visible pixel followed by blanking; returns the ROM request and
    // the resulting output pixel.
    task automatic probe(input int x, input int y, output logic [1:0] cs,
                         output logic [18:0] a, output logic [5:0] rgb, output logic vld);
        set_px(x, y, 1'b1);
        tick();
        VideoOn = 1'b0;
        tick();
        cs = ChipSelector;
        a  = Address;
        tick();
        rgb = RGB;
        vld = RGBValid;
        $display("px (%0d,%0d) cs=%b addr=%0d rgb=%h valid=%b", x, y, cs, a, rgb, vld);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        set_px(0, 0, 1'b0);
        Digits = 24'h0; CronoOn = 1'b0; EditField = 2'd0;
        tick();
        tick();
        total++; if (ChipSelector !== 2'b00) begin bad++; $display("FAIL reset_cs got=%b want=00", ChipSelector); end
        total++; if (Address !== 19'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", Address); end
        total++; if (RGB !== 6'd0) begin bad++; $display("FAIL reset_rgb got=%h want=0", RGB); end
        total++; if (RGBValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", RGBValid); end
        RESET = 1'b0;
        tick();
        $display("reset released");
    endtask

    task automatic test_bg_stream();
        logic [18:0] exp_a [5];
        logic        exp_v [5];
        logic [5:0]  exp_rgb [5];
        exp_a[0] = 19'd0; exp_a[1] = 19'd1; exp_a[2] = 19'd2; exp_a[3] = 19'd2; exp_a[4] = 19'd2;
        exp_v[0] = 1'b0;  exp_v[1] = 1'b1;  exp_v[2] = 1'b1;  exp_v[3] = 1'b1;  exp_v[4] = 1'b0;
        exp_rgb[0] = 6'd0;
        exp_rgb[1] = rom_fn(2'b00, 19'd0);
        exp_rgb[2] = rom_fn(2'b00, 19'd1);
        exp_rgb[3] = rom_fn(2'b00, 19'd2);
        exp_rgb[4] = 6'd0;
        set_px(0, 0, 1'b1);
        tick();
        set_px(1, 0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) set_px(2, 0, 1'b1);
            if (c == 1) VideoOn = 1'b0;
            $display("stream edge %0d cs=%b addr=%0d rgb=%h valid=%b", c + 2, ChipSelector, Address, RGB, RGBValid);
            total++; if (ChipSelector !== 2'b00) begin bad++; $display("FAIL stream_cs[%0d] got=%b want=00", c + 2, ChipSelector); end
            total++; if (Address !== exp_a[c]) begin bad++; $display("FAIL stream_addr[%0d] got=%0d want=%0d", c + 2, Address, exp_a[c]); end
            total++; if (RGBValid !== exp_v[c]) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=%b", c + 2, RGBValid, exp_v[c]); end
            total++; if (RGB !== exp_rgb[c]) begin bad++; $display("FAIL stream_rgb[%0d] got=%h want=%h", c + 2, RGB, exp_rgb[c]); end
        end
    endtask

    // Table of probes: x, y, expected chip select, expected address.
    task automatic run_table(input string name, input int n, input int tx [8], input int ty [8],
                             input logic [1:0] tcs [8], input logic [18:0] ta [8]);
        logic [1:0]  cs;
        logic [18:0] a;
        logic [5:0]  rgb;
        logic        vld;
        for (int i = 0; i < n; i++) begin
            probe(tx[i], ty[i], cs, a, rgb, vld);
            total++; if (cs !== tcs[i]) begin bad++; $display("FAIL %s_cs[%0d] got=%b want=%b", name, i, cs, tcs[i]); end
            total++; if (a !== ta[i]) begin bad++; $display("FAIL %s_addr[%0d] got=%0d want=%0d", name, i, a, ta[i]); end
            total++; if (vld !== 1'b1) begin bad++; $display("FAIL %s_valid[%0d] got=%b want=1", name, i, vld); end
            total++; if (rgb !== rom_fn(tcs[i], ta[i])) begin bad++; $display("FAIL %s_rgb[%0d] got=%h want=%h", name, i, rgb, rom_fn(tcs[i], ta[i])); end
        end
    endtask

    task automatic test_digits();
        int          tx [8] = '{221, 160, 479, 480, 200, 160, 0, 0};
        int          ty [8] = '{210, 200, 259, 259, 200, 199, 0, 0};
        logic [1:0]  tcs [8] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [18:0] ta [8] = '{19'd5205, 19'd2400, 19'd16799, 19'd166240, 19'd128200, 19'd127520, 19'd0, 19'd0};
        frame_start(24'h123456, 1'b0, 2'd0);
        run_table("digit", 6, tx, ty, tcs, ta);
    endtask

    task automatic test_crono();
        int          tx [8] = '{275, 369, 370, 270, 269, 0, 0, 0};
        int          ty [8] = '{330, 359, 359, 320, 320, 0, 0, 0};
        logic [1:0]  tcs [8] = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [18:0] ta [8] = '{19'd1005, 19'd3999, 19'd230130, 19'd0, 19'd205069, 19'd0, 19'd0, 19'd0};
        int          ox [8] = '{275, 0, 0, 0, 0, 0, 0, 0};
        int          oy [8] = '{330, 0, 0, 0, 0, 0, 0, 0};
        logic [1:0]  ocs [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [18:0] oa [8] = '{19'd211475, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0};
        frame_start(24'h123456, 1'b1, 2'd0);
        run_table("crono_on", 5, tx, ty, tcs, ta);
        frame_start(24'h123456, 1'b0, 2'd0);
        run_table("crono_off", 1, ox, oy, ocs, oa);
    endtask

    task automatic test_frame_shadow();
        int          mx [8] = '{300, 221, 275, 0, 0, 0, 0, 0};
        int          my [8] = '{240, 210, 330, 0, 0, 0, 0, 0};
        logic [1:0]  mcs [8] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [18:0] ma [8] = '{19'd8828, 19'd5205, 19'd211475, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0};
        int          nx [8] = '{221, 0, 0, 0, 0, 0, 0, 0};
        int          ny [8] = '{210, 0, 0, 0, 0, 0, 0, 0};
        logic [1:0]  ncs [8] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [18:0] na [8] = '{19'd22005, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0};
        int          ix [8] = '{165, 221, 0, 0, 0, 0, 0, 0};
        int          iy [8] = '{205, 210, 0, 0, 0, 0, 0, 0};
        logic [1:0]  ics [8] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [18:0] ia [8] = '{19'd131365, 19'd405, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0};
        frame_start(24'h123456, 1'b0, 2'd0);
        // Mid-frame input changes must not reach the decode.
        Digits  = 24'h999999;
        CronoOn = 1'b1;
        run_table("tear", 3, mx, my, mcs, ma);
        frame_start(24'h999999, 1'b0, 2'd0);
        run_table("newframe", 1, nx, ny, ncs, na);
        frame_start(24'hA00000, 1'b0, 2'd0);
        run_table("badbcd", 2, ix, iy, ics, ia);
    endtask

    task automatic test_reset_midrun();
        frame_start(24'h123456, 1'b1, 2'd2);
        set_px(221, 210, 1'b1);
        tick();
        tick();
        tick();
        total++; if (RGBValid !== 1'b1) begin bad++; $display("FAIL midrun_pre_valid got=%b want=1", RGBValid); end
        RESET = 1'b1;
        #1;
        $display("reset mid-run cs=%b addr=%0d rgb=%h valid=%b", ChipSelector, Address, RGB, RGBValid);
        total++; if (RGB !== 6'd0) begin bad++; $display("FAIL midrun_rgb got=%h want=0", RGB); end
        total++; if (RGBValid !== 1'b0) begin bad++; $display("FAIL midrun_valid got=%b want=0", RGBValid); end
        total++; if (ChipSelector !== 2'b00) begin bad++; $display("FAIL midrun_cs got=%b want=00", ChipSelector); end
        total++; if (Address !== 19'd0) begin bad++; $display("FAIL midrun_addr got=%0d want=0", Address); end
        tick();
        tick();
        RESET = 1'b0;
        // Pixel (221,210) keeps streaming; shadow is now zero so slot 1 shows glyph 0.
        tick();
        total++; if (RGBValid !== 1'b0) begin bad++; $display("FAIL recover_valid1 got=%b want=0", RGBValid); end
        tick();
        total++; if (RGBValid !== 1'b0) begin bad++; $display("FAIL recover_valid2 got=%b want=0", RGBValid); end
        total++; if (ChipSelector !== 2'b01) begin bad++; $display("FAIL recover_cs got=%b want=01", ChipSelector); end
        total++; if (Address !== 19'd405) begin bad++; $display("FAIL recover_addr got=%0d want=405", Address); end
        tick();
        $display("recovered cs=%b addr=%0d rgb=%h valid=%b", ChipSelector, Address, RGB, RGBValid);
        total++; if (RGBValid !== 1'b1) begin bad++; $display("FAIL recover_valid3 got=%b want=1", RGBValid); end
        total++; if (RGB !== rom_fn(2'b01, 19'd405)) begin bad++; $display("FAIL recover_rgb got=%h want=%h", RGB, rom_fn(2'b01, 19'd405)); end
        VideoOn = 1'b0;
        tick();
        tick();
        tick();
    endtask

`ifdef VROM_EDIT_BLINK_EN
    // Frame counter is 0 after the mid-run reset; each frame_start adds one.
    task automatic test_blink();
        logic [1:0]  cs;
        logic [18:0] a;
        logic [5:0]  rgb;
        logic        vld;
        for (int f = 0; f < 15; f++) frame_start(24'h123456, 1'b0, 2'd2);
        probe(277, 205, cs, a, rgb, vld);
        total++; if (rgb !== rom_fn(2'b01, 19'd7405)) begin bad++; $display("FAIL blink_f15_min got=%h want=%h", rgb, rom_fn(2'b01, 19'd7405)); end
        frame_start(24'h123456, 1'b0, 2'd2);
        probe(277, 205, cs, a, rgb, vld);
        total++; if (rgb !== ~rom_fn(2'b01, 19'd7405)) begin bad++; $display("FAIL blink_f16_min got=%h want=%h", rgb, ~rom_fn(2'b01, 19'd7405)); end
        probe(165, 205, cs, a, rgb, vld);
        total++; if (rgb !== rom_fn(2'b01, 19'd2605)) begin bad++; $display("FAIL blink_f16_hour got=%h want=%h", rgb, rom_fn(2'b01, 19'd2605)); end
        probe(389, 205, cs, a, rgb, vld);
        total++; if (rgb !== rom_fn(2'b01, 19'd12205)) begin bad++; $display("FAIL blink_f16_sec got=%h want=%h", rgb, rom_fn(2'b01, 19'd12205)); end
        for (int f = 0; f < 16; f++) frame_start(24'h123456, 1'b0, 2'd2);
        probe(277, 205, cs, a, rgb, vld);
        total++; if (rgb !== rom_fn(2'b01, 19'd7405)) begin bad++; $display("FAIL blink_f0_min got=%h want=%h", rgb, rom_fn(2'b01, 19'd7405)); end
    endtask
`endif

    initial begin
        RESET = 1'b1;
        set_px(0, 0, 1'b0);
        Digits = 24'h0; CronoOn = 1'b0; EditField = 2'd0;
        test_reset();
        test_bg_stream();
        test_digits();
        test_crono();
        test_frame_shadow();
        test_reset_midrun();
`ifdef VROM_EDIT_BLINK_EN
        test_blink();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
